// File: rtl/sram_like_arbiter_pkg.sv
// rtl/sram_like_arbiter_pkg.sv - shared IDs, size encodings and request field bundle
// Purpose: constants and types shared by the arbiter top and its ID FIFO.
// Ports: none (package).
package sram_like_arbiter_pkg;

  // Owner ID stored per outstanding request.
  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  // Access size encodings carried on *_size.
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Request fields forwarded from the granted master to the memory port.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_fields_t;

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// rtl/sram_like_arbiter_id_fifo.sv - in-order owner-ID FIFO for outstanding requests
// Purpose: remembers which master issued each accepted request so responses
//          can be routed back in order.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   push, push_id   enqueue one owner ID (ignored when full)
//   pop             dequeue the head entry (ignored when empty)
//   count           number of stored entries
//   full, empty     occupancy flags
//   head            owner ID at the head of the FIFO
module id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       push_id,
  input  logic                       pop,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0] ids;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign head    = ids[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ids    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        ids[wr_ptr] <= push_id;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - two-master arbiter onto one sram-like memory port
// Purpose: shares a req/addr_ok/data_ok memory port between instruction fetch
//          and the data master; data has priority, fetch is protected by an
//          anti-starvation counter, responses are routed by an in-order ID FIFO.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   inst_sram_*                     fetch master request in, addr_ok/data_ok/rdata out
//   data_sram_*                     data master request in, addr_ok/data_ok/rdata out
//   mem_req, mem_wr/size/wstrb/addr/wdata   forwarded request to the slave
//   mem_addr_ok, mem_data_ok, mem_rdata     slave handshake and response
//   resp_err                        sticky: response seen with nothing outstanding
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        resp_err
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  req_fields_t inst_f;
  req_fields_t data_f;
  req_fields_t gnt_f;

  logic             grant_valid;
  logic             grant_id;
  logic             handshake;
  logic             lock_valid;
  logic             lock_id;
  logic             locked_req_held;
  logic [SC_W-1:0]  starve_cnt;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_head;
  logic             rsp_valid;

  assign inst_f = '{wr: inst_sram_wr, size: inst_sram_size, wstrb: inst_sram_wstrb,
                    addr: inst_sram_addr, wdata: inst_sram_wdata};
  assign data_f = '{wr: data_sram_wr, size: data_sram_size, wstrb: data_sram_wstrb,
                    addr: data_sram_addr, wdata: data_sram_wdata};

  assign locked_req_held = (lock_id == ID_INST) ? inst_sram_req : data_sram_req;

  // Full deliberately ignores a same-cycle pop so mem_req never depends on mem_data_ok.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = ID_DATA;
    if (!reset && !fifo_full) begin
      if (lock_valid && locked_req_held) begin
        grant_valid = 1'b1;
        grant_id    = lock_id;
      end else if (starve_cnt == STARVE_MAX && inst_sram_req) begin
        grant_valid = 1'b1;
        grant_id    = ID_INST;
      end else if (data_sram_req) begin
        grant_valid = 1'b1;
        grant_id    = ID_DATA;
      end else if (inst_sram_req) begin
        grant_valid = 1'b1;
        grant_id    = ID_INST;
      end
    end
  end

  // With no grant, grant_id defaults to data, so idle fields follow the data master.
  assign gnt_f     = (grant_id == ID_INST) ? inst_f : data_f;
  assign mem_req   = grant_valid;
  assign mem_wr    = gnt_f.wr;
  assign mem_size  = gnt_f.size;
  assign mem_wstrb = gnt_f.wstrb;
  assign mem_addr  = gnt_f.addr;
  assign mem_wdata = gnt_f.wdata;

  assign handshake         = grant_valid & mem_addr_ok;
  assign inst_sram_addr_ok = handshake & (grant_id == ID_INST);
  assign data_sram_addr_ok = handshake & (grant_id == ID_DATA);

  assign rsp_valid         = mem_data_ok & ~fifo_empty & ~reset;
  assign inst_sram_data_ok = rsp_valid & (fifo_head == ID_INST);
  assign data_sram_data_ok = rsp_valid & (fifo_head == ID_DATA);
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;

  id_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (handshake),
    .push_id(grant_id),
    .pop    (mem_data_ok),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_valid <= 1'b0;
      lock_id    <= ID_INST;
      starve_cnt <= '0;
      resp_err   <= 1'b0;
    end else begin
      // A request left waiting keeps its master on the bus until accepted or withdrawn.
      if (handshake) begin
        lock_valid <= 1'b0;
      end else if (grant_valid) begin
        lock_valid <= 1'b1;
        lock_id    <= grant_id;
      end else if (lock_valid && !locked_req_held) begin
        lock_valid <= 1'b0;
      end

      if (!inst_sram_req) begin
        starve_cnt <= '0;
      end else if (handshake && grant_id == ID_INST) begin
        starve_cnt <= '0;
      end else if (handshake && starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      if (mem_data_ok && fifo_empty) begin
        resp_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - self-checking bench for sram_like_arbiter
module tb_sram_like_arbiter;
  import sram_like_arbiter_pkg::*;

  localparam int MAX_OUT = 4;
  localparam int LIMIT   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_sram_req, inst_sram_wr, data_sram_req, data_sram_wr;
  logic [1:0]  inst_sram_size, data_sram_size;
  logic [3:0]  inst_sram_wstrb, data_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata, data_sram_addr, data_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] inst_sram_rdata, data_sram_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  sram_like_arbiter #(.MAX_OUTSTANDING(MAX_OUT), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  // Reference model: owner queue plus lock / starvation bookkeeping.
  bit q[$];
  bit m_lock_v, m_lock_id, m_err;
  int m_starve;
  bit e_req, e_gid, e_inst_aok, e_data_aok, e_inst_dok, e_data_dok;
  logic [31:0] e_addr, e_wdata;

  task automatic idle();
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = SIZE_W; inst_sram_wstrb = 4'h0;
    inst_sram_addr = 32'h0; inst_sram_wdata = 32'h0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = SIZE_W; data_sram_wstrb = 4'h0;
    data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    q.delete(); m_lock_v = 0; m_lock_id = 0; m_err = 0; m_starve = 0;
  endtask

  task automatic eval_model();
    e_req = 0; e_gid = 1;
    if (q.size() < MAX_OUT) begin
      if (m_lock_v && (m_lock_id ? data_sram_req : inst_sram_req)) begin e_req = 1; e_gid = m_lock_id; end
      else if (m_starve == LIMIT && inst_sram_req) begin e_req = 1; e_gid = 0; end
      else if (data_sram_req) begin e_req = 1; e_gid = 1; end
      else if (inst_sram_req) begin e_req = 1; e_gid = 0; end
    end
    e_addr     = (e_req && !e_gid) ? inst_sram_addr : data_sram_addr;
    e_wdata    = (e_req && !e_gid) ? inst_sram_wdata : data_sram_wdata;
    e_inst_aok = e_req && !e_gid && mem_addr_ok;
    e_data_aok = e_req && e_gid && mem_addr_ok;
    e_inst_dok = mem_data_ok && q.size() > 0 && q[0] == 1'b0;
    e_data_dok = mem_data_ok && q.size() > 0 && q[0] == 1'b1;
  endtask

  task automatic commit_model();
    bit hs;
    hs = e_req && mem_addr_ok;
    if (mem_data_ok) begin
      if (q.size() > 0) void'(q.pop_front());
      else m_err = 1;
    end
    if (hs) q.push_back(e_gid);
    if (hs) m_lock_v = 0;
    else if (e_req) begin m_lock_v = 1; m_lock_id = e_gid; end
    else if (m_lock_v && !(m_lock_id ? data_sram_req : inst_sram_req)) m_lock_v = 0;
    if (!inst_sram_req) m_starve = 0;
    else if (hs && !e_gid) m_starve = 0;
    else if (hs && m_starve < LIMIT) m_starve++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    inst_sram_req = 1; data_sram_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %0b exp 0", mem_req); end
    checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b00) begin errors++; $display("FAIL reset_addr_ok got %b exp 00", {inst_sram_addr_ok, data_sram_addr_ok}); end
    checks++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin errors++; $display("FAIL reset_data_ok got %b exp 00", {inst_sram_data_ok, data_sram_data_ok}); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %0b exp 0", resp_err); end
    do_reset();
  endtask

  task automatic test_single_fetch();
    do_reset();
    inst_sram_req = 1; inst_sram_addr = 32'h1c000000; mem_addr_ok = 1;
    @(negedge clk);
    checks++; if (inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL fetch_addr_ok got %0b exp 1", inst_sram_addr_ok); end
    checks++; if (mem_addr !== 32'h1c000000) begin errors++; $display("FAIL fetch_mem_addr got %0h exp 1c000000", mem_addr); end
    checks++; if (data_sram_addr_ok !== 1'b0) begin errors++; $display("FAIL fetch_data_addr_ok got %0b exp 0", data_sram_addr_ok); end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    checks++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin errors++; $display("FAIL fetch_early_data_ok got %b exp 00", {inst_sram_data_ok, data_sram_data_ok}); end
    @(posedge clk); #1;
    mem_data_ok = 1; mem_rdata = 32'h02800c0c;
    @(negedge clk);
    checks++; if (inst_sram_data_ok !== 1'b1) begin errors++; $display("FAIL fetch_data_ok got %0b exp 1", inst_sram_data_ok); end
    checks++; if (inst_sram_rdata !== 32'h02800c0c) begin errors++; $display("FAIL fetch_rdata got %0h exp 02800c0c", inst_sram_rdata); end
    checks++; if (data_sram_data_ok !== 1'b0) begin errors++; $display("FAIL fetch_data_side got %0b exp 0", data_sram_data_ok); end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_both_masters();
    do_reset();
    inst_sram_req = 1; inst_sram_addr = 32'h1c000004;
    data_sram_req = 1; data_sram_addr = 32'h8; data_sram_wr = 1; data_sram_wstrb = 4'b1111;
    data_sram_wdata = 32'hdeadbeef; mem_addr_ok = 1;
    @(negedge clk);
    checks++; if (mem_addr !== 32'h8 || mem_wr !== 1'b1 || mem_wstrb !== 4'hf || mem_wdata !== 32'hdeadbeef) begin
      errors++; $display("FAIL both_fields got addr=%0h wr=%0b wstrb=%0h wdata=%0h exp 8/1/f/deadbeef", mem_addr, mem_wr, mem_wstrb, mem_wdata); end
    checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b01) begin errors++; $display("FAIL both_first_grant got %b exp 01", {inst_sram_addr_ok, data_sram_addr_ok}); end
    @(posedge clk); #1;
    data_sram_req = 0;
    @(negedge clk);
    checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b10 || mem_addr !== 32'h1c000004) begin
      errors++; $display("FAIL both_second_grant got ok=%b addr=%0h exp 10/1c000004", {inst_sram_addr_ok, data_sram_addr_ok}, mem_addr); end
    @(posedge clk); #1;
    idle(); mem_data_ok = 1; mem_rdata = 32'h11111111;
    @(negedge clk);
    checks++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b01) begin errors++; $display("FAIL both_rsp1 got %b exp 01", {inst_sram_data_ok, data_sram_data_ok}); end
    @(posedge clk); #1;
    mem_rdata = 32'h22222222;
    @(negedge clk);
    checks++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b10) begin errors++; $display("FAIL both_rsp2 got %b exp 10", {inst_sram_data_ok, data_sram_data_ok}); end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_lock();
    do_reset();
    data_sram_req = 1; data_sram_addr = 32'h300; inst_sram_req = 1; inst_sram_addr = 32'h1c000000;
    for (int i = 0; i < 4; i++) begin
      mem_addr_ok = (i == 3);
      @(negedge clk);
      checks++; if (mem_addr !== 32'h300 || data_sram_addr_ok !== (i == 3)) begin
        errors++; $display("FAIL lock_data_cyc%0d got addr=%0h aok=%0b exp 300/%0b", i, mem_addr, data_sram_addr_ok, (i == 3)); end
      @(posedge clk); #1;
    end
    // Fetch holds the bus while waiting even after the higher-priority data master arrives.
    do_reset();
    inst_sram_req = 1; inst_sram_addr = 32'h1c000010;
    @(posedge clk); #1;
    data_sram_req = 1; data_sram_addr = 32'h400;
    @(negedge clk);
    checks++; if (mem_addr !== 32'h1c000010) begin errors++; $display("FAIL lock_inst_hold got %0h exp 1c000010", mem_addr); end
    @(posedge clk); #1;
    mem_addr_ok = 1;
    @(negedge clk);
    checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b10) begin errors++; $display("FAIL lock_inst_accept got %b exp 10", {inst_sram_addr_ok, data_sram_addr_ok}); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b01) begin errors++; $display("FAIL lock_release got %b exp 01", {inst_sram_addr_ok, data_sram_addr_ok}); end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_full();
    bit owners[4];
    bit order[4];
    owners = '{1'b1, 1'b0, 1'b1, 1'b0};
    order  = '{1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle(); mem_addr_ok = 1;
      if (owners[i]) begin data_sram_req = 1; data_sram_addr = 32'(i * 4); end
      else begin inst_sram_req = 1; inst_sram_addr = 32'h1c000000 + 32'(i * 4); end
      @(negedge clk);
      checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== {!owners[i], owners[i]}) begin
        errors++; $display("FAIL full_push%0d got %b exp %b", i, {inst_sram_addr_ok, data_sram_addr_ok}, {!owners[i], owners[i]}); end
      @(posedge clk); #1;
    end
    inst_sram_req = 1; data_sram_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || {inst_sram_addr_ok, data_sram_addr_ok} !== 2'b00) begin
      errors++; $display("FAIL full_block got req=%0b ok=%b exp 0/00", mem_req, {inst_sram_addr_ok, data_sram_addr_ok}); end
    checks++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b01) begin errors++; $display("FAIL full_pop got %b exp 01", {inst_sram_data_ok, data_sram_data_ok}); end
    @(posedge clk); #1;
    data_sram_req = 0; mem_data_ok = 0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL full_reaccept got req=%0b ok=%0b exp 1/1", mem_req, inst_sram_addr_ok); end
    @(posedge clk); #1;
    idle();
    for (int k = 0; k < 4; k++) begin
      mem_data_ok = 1;
      @(negedge clk);
      checks++; if ({inst_sram_data_ok, data_sram_data_ok} !== {!order[k], order[k]}) begin
        errors++; $display("FAIL full_rsp%0d got %b exp %b", k, {inst_sram_data_ok, data_sram_data_ok}, {!order[k], order[k]}); end
      @(posedge clk); #1;
    end
    idle();
  endtask

  task automatic test_starvation();
    bit prev_data;
    bit exp_inst;
    do_reset();
    inst_sram_req = 1; inst_sram_addr = 32'h1c000000; data_sram_req = 1; data_sram_addr = 32'h200; mem_addr_ok = 1;
    prev_data = 0;
    for (int i = 0; i < 10; i++) begin
      mem_data_ok = (i > 0);
      exp_inst = (i % 5 == 4);
      @(negedge clk);
      checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== {exp_inst, !exp_inst}) begin
        errors++; $display("FAIL starve_grant%0d got %b exp %b", i, {inst_sram_addr_ok, data_sram_addr_ok}, {exp_inst, !exp_inst}); end
      if (i > 0) begin
        checks++; if ({inst_sram_data_ok, data_sram_data_ok} !== {!prev_data, prev_data}) begin
          errors++; $display("FAIL starve_rsp%0d got %b exp %b", i, {inst_sram_data_ok, data_sram_data_ok}, {!prev_data, prev_data}); end
      end
      prev_data = !exp_inst;
      @(posedge clk); #1;
    end
    idle();
  endtask

  task automatic test_error_and_reset();
    do_reset();
    mem_data_ok = 1;
    @(negedge clk);
    checks++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin errors++; $display("FAIL err_no_data_ok got %b exp 00", {inst_sram_data_ok, data_sram_data_ok}); end
    @(posedge clk); #1;
    mem_data_ok = 0;
    @(negedge clk);
    checks++; if (resp_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b exp 1", resp_err); end
    @(posedge clk); #1;
    data_sram_req = 1; mem_addr_ok = 1;
    repeat (2) @(posedge clk);
    #1;
    idle();
    #1;
    reset = 1'b1;
    #1;
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL async_resp_err got %0b exp 0", resp_err); end
    checks++; if (dut.u_fifo.count !== 3'd0) begin errors++; $display("FAIL async_count got %0d exp 0", dut.u_fifo.count); end
    data_sram_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    #1;
    checks++; if (mem_req !== 1'b0 || data_sram_addr_ok !== 1'b0 || data_sram_data_ok !== 1'b0) begin
      errors++; $display("FAIL async_gate got req=%0b aok=%0b dok=%0b exp 0/0/0", mem_req, data_sram_addr_ok, data_sram_data_ok); end
    @(negedge clk);
    idle();
    reset = 1'b0;
    @(posedge clk); #1;
    data_sram_req = 1; mem_addr_ok = 1;
    @(negedge clk);
    checks++; if (data_sram_addr_ok !== 1'b1 || resp_err !== 1'b0) begin
      errors++; $display("FAIL post_reset got aok=%0b err=%0b exp 1/0", data_sram_addr_ok, resp_err); end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      inst_sram_req   = ($urandom_range(0, 9) < 7);
      inst_sram_addr  = 32'h1c000000 | ($urandom & 32'hfffc);
      inst_sram_wdata = $urandom;
      data_sram_req   = ($urandom_range(0, 9) < 6);
      data_sram_wr    = $urandom_range(0, 1);
      data_sram_addr  = $urandom & 32'h0000fffc;
      data_sram_wdata = $urandom;
      data_sram_wstrb = 4'($urandom);
      mem_addr_ok     = ($urandom_range(0, 3) != 0);
      mem_data_ok     = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_rdata       = $urandom;
      @(negedge clk);
      eval_model();
      checks++; if (mem_req !== e_req) begin errors++; $display("FAIL rand_req cyc%0d got %0b exp %0b", n, mem_req, e_req); end
      checks++; if (mem_addr !== e_addr || mem_wdata !== e_wdata) begin
        errors++; $display("FAIL rand_fields cyc%0d got %0h/%0h exp %0h/%0h", n, mem_addr, mem_wdata, e_addr, e_wdata); end
      checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== {e_inst_aok, e_data_aok}) begin
        errors++; $display("FAIL rand_addr_ok cyc%0d got %b exp %b", n, {inst_sram_addr_ok, data_sram_addr_ok}, {e_inst_aok, e_data_aok}); end
      checks++; if ({inst_sram_data_ok, data_sram_data_ok} !== {e_inst_dok, e_data_dok}) begin
        errors++; $display("FAIL rand_data_ok cyc%0d got %b exp %b", n, {inst_sram_data_ok, data_sram_data_ok}, {e_inst_dok, e_data_dok}); end
      checks++; if (inst_sram_rdata !== mem_rdata || data_sram_rdata !== mem_rdata) begin
        errors++; $display("FAIL rand_rdata cyc%0d got %0h/%0h exp %0h", n, inst_sram_rdata, data_sram_rdata, mem_rdata); end
      checks++; if (resp_err !== m_err) begin errors++; $display("FAIL rand_resp_err cyc%0d got %0b exp %0b", n, resp_err, m_err); end
      commit_model();
      @(posedge clk); #1;
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single_fetch();
    test_both_masters();
    test_lock();
    test_full();
    test_starvation();
    test_error_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
